ut_param_core: RTL and testbench
================================

UT_PARAM_CORE -- requirements
Module: ut_param_core

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal range 4..32).
REQ-002 Parameter NACC, default 2, number of accumulators (legal range 1..8); AW = max(1, clog2(NACC)).
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ce  in  1  clock enable; when low, no register, flag or FSM state changes.
REQ-006 sel_ual  in  3  operation select: 000 NOR, 001 PASS_R1, 010 ADD, 011 SUB, 100 MUL; 101..111 reserved.
REQ-007 acc_sel  in  AW  accumulator index for ALU operand, write-back and data_out.
REQ-008 data_in  in  WIDTH  operand loaded into R1.
REQ-009 load_r1, load_acc, load_carry, init_carry  in  1 each  register load strobes, qualified by ce.
REQ-010 start  in  1  multiply request, valid only with sel_ual=100.
REQ-011 busy  out  1  multiply in progress.
REQ-012 done  out  1  one-cycle pulse on multiply completion.
REQ-013 carry  out  1  carry flag register.
REQ-014 zero  out  1  combinational: ACC[acc_sel] == 0.
REQ-015 data_out  out  WIDTH  combinational: ACC[acc_sel].

Function
REQ-016 Combinational ALU, with A = ACC[acc_sel] and B = R1: NOR = ~(A|B); PASS_R1 = B; ADD = (A+B) mod 2^WIDTH; SUB = (A-B) mod 2^WIDTH; reserved codes and 100 = 0.
REQ-017 ALU carry: ADD -> bit WIDTH of the unsigned (WIDTH+1)-bit sum; SUB -> 1 if A<B unsigned; all other codes -> 0.
REQ-018 R1 <= data_in on a clock edge with ce=1 and load_r1=1; R1 loads even while busy.
REQ-019 ACC[acc_sel] <= ALU result on a clock edge with ce=1, load_acc=1, busy=0, and not (start=1 with sel_ual=100); otherwise that accumulator holds.
REQ-020 Carry, when ce=1: load_carry=1 loads the ALU carry; else init_carry=1 clears it; else it holds. load_carry has priority over init_carry.
REQ-021 The multiply FSM has three states: IDLE, RUN, FIN.
REQ-022 In IDLE, start=1 with sel_ual=100 and ce=1 performs all of the following: latch multiplicand = R1, multiplier = ACC[acc_sel], index = acc_sel; clear the 2*WIDTH product; go to RUN.
REQ-023 In RUN, each ce=1 edge performs one shift-add step (add the multiplicand if the multiplier LSB is 1, then shift). After WIDTH steps, go to FIN. Edges with ce=0 stall the step.
REQ-024 In FIN on a ce=1 edge, all of the following happen, then the FSM returns to IDLE:
  - ACC[latched index] <= product[WIDTH-1:0];
  - carry <= (product[2*WIDTH-1:WIDTH] != 0);
  - done = 1 for exactly that cycle.
REQ-025 busy = 1 in RUN and FIN; busy = 0 in IDLE.
REQ-026 Latency with ce held high: start sampled at edge 0 gives done=1 and the written result visible after edge WIDTH+1.
REQ-027 Ignored while busy: start, load_acc, load_carry, init_carry. Changes on acc_sel and R1 do not affect the operation in flight.
REQ-028 start with sel_ual != 100 is ignored; reserved sel_ual codes with load_acc=1 write 0.
REQ-029 Product arithmetic is unsigned; the product never overflows its 2*WIDTH bits.

Reset
REQ-030 rst=1 asynchronously sets all of the following, regardless of ce: every ACC = 0, R1 = 0, carry = 0, FSM = IDLE, busy = 0, done = 0, product = 0.
REQ-031 rst asserted mid-multiply aborts the operation: no write-back and no done pulse.

Configuration
REQ-032 Macro UT_PARAM_MUL_EN defined: the MUL path and FSM (REQ-021..REQ-027, REQ-029) are compiled in.
REQ-033 Macro UT_PARAM_MUL_EN undefined: no FSM or product logic; busy and done are tied 0; sel_ual=100 behaves as a reserved code; start is ignored.

Verification
REQ-034 WIDTH=16, NACC=2: R1=0x00F0, ACC0=0x0F00; NOR, load_acc -> ACC0 = 0xF00F, carry unchanged.
REQ-035 ACC0=0xFFFF, R1=0x0001; ADD with load_acc and load_carry -> ACC0 = 0x0000, carry = 1, zero = 1.
REQ-036 ACC1=0x0003, R1=0x0005, acc_sel=1; SUB with load_acc and load_carry -> ACC1 = 0xFFFE, carry = 1; ACC0 unchanged.
REQ-037 UT_PARAM_MUL_EN defined, ACC0=0x1234, R1=0x0100; start -> busy for 17 cycles, done at edge 17, ACC0 = 0x3400, carry = 1; load_acc pulsed mid-run has no effect.
REQ-038 Multiply as in REQ-037, with ce low for 3 cycles mid-run -> done delayed by exactly 3 cycles. Same multiply with rst pulsed at cycle 5 -> all outputs 0 and no done pulse.
REQ-039 load_carry and init_carry asserted together on a SUB with A<B -> carry = 1.

Source files
------------

// File: rtl/ut_param_core_if.sv
// Operand, strobe and status bundle for ut_param_core; the master side drives
// the control inputs and the slave side is the core itself.
interface ut_param_core_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 1
) ();
  logic             ce;
  logic [2:0]       sel_ual;
  logic [AW-1:0]    acc_sel;
  logic [WIDTH-1:0] data_in;
  logic             load_r1;
  logic             load_acc;
  logic             load_carry;
  logic             init_carry;
  logic             start;
  logic             busy;
  logic             done;
  logic             carry;
  logic             zero;
  logic [WIDTH-1:0] data_out;

  modport master (
    output ce, sel_ual, acc_sel, data_in,
    output load_r1, load_acc, load_carry, init_carry, start,
    input  busy, done, carry, zero, data_out
  );

  modport slave (
    input  ce, sel_ual, acc_sel, data_in,
    input  load_r1, load_acc, load_carry, init_carry, start,
    output busy, done, carry, zero, data_out
  );
endinterface

// File: rtl/ut_param_core.sv
// Accumulator datapath with a small ALU and an optional shift-add multiplier,
// compiled in only when the macro UT_PARAM_MUL_EN is defined.
module ut_param_core #(
  parameter int  WIDTH = 16,
  parameter int  NACC  = 2,
  localparam int AW    = (NACC > 1) ? $clog2(NACC) : 1
) (
  input logic            clk,
  input logic            rst,
  ut_param_core_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOR  = 3'b000,
    OP_PASS = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100
  } op_e;

  logic [WIDTH-1:0] acc_q [NACC];
  logic [WIDTH-1:0] acc_d [NACC];
  logic [WIDTH-1:0] r1_q, r1_d;
  logic             carry_q, carry_d;

  logic             sel_ok;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic [WIDTH:0]   sum;

  logic             busy_w;
  logic             mul_req;
  logic             mul_wb;
  logic [AW-1:0]    mul_idx;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_cy;

  // An acc_sel beyond NACC (non power-of-two NACC) reads as zero and never writes.
  assign sel_ok = (32'(bus.acc_sel) < NACC);
  assign op_a   = sel_ok ? acc_q[bus.acc_sel] : '0;
  assign op_b   = r1_q;

  always_comb begin : alu
    alu_res = '0;
    alu_cy  = 1'b0;
    sum     = {1'b0, op_a} + {1'b0, op_b};
    case (op_e'(bus.sel_ual))
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_PASS: alu_res = op_b;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_cy  = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_cy  = (op_a < op_b);
      end
      default: ;
    endcase
  end

`ifdef UT_PARAM_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               done_q, done_d;

  assign mul_req = bus.start && (bus.sel_ual == OP_MUL);

  always_comb begin : mul_fsm
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    idx_d    = idx_q;
    mul_wb   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ce && mul_req) begin
          mcand_d  = {{WIDTH{1'b0}}, op_b};
          mplier_d = op_a;
          idx_d    = bus.acc_sel;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.ce) begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (bus.ce) begin
          mul_wb  = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // done is a pulse: it is recomputed every edge so it never lingers past one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign busy_w   = (state_q != S_IDLE);
  assign mul_idx  = idx_q;
  assign mul_lo   = prod_q[WIDTH-1:0];
  assign mul_cy   = |prod_q[2*WIDTH-1:WIDTH];
  assign bus.busy = busy_w;
  assign bus.done = done_q;
`else
  logic unused_start;

  assign unused_start = bus.start;
  assign mul_req      = 1'b0;
  assign mul_wb       = 1'b0;
  assign mul_idx      = '0;
  assign mul_lo       = '0;
  assign mul_cy       = 1'b0;
  assign busy_w       = 1'b0;
  assign bus.busy     = 1'b0;
  assign bus.done     = 1'b0;
`endif

  always_comb begin : datapath
    // NOTE: every variable gets its hold value first so no path through the
    // branches below can leave it unassigned and infer a latch.
    acc_d   = acc_q;
    r1_d    = r1_q;
    carry_d = carry_q;
    if (bus.ce) begin
      if (bus.load_r1) r1_d = bus.data_in;
      if (mul_wb) begin
        if (32'(mul_idx) < NACC) acc_d[mul_idx] = mul_lo;
        carry_d = mul_cy;
      end else if (!busy_w) begin
        // A multiply launch consumes the ALU slot, so it suppresses write-back.
        if (bus.load_acc && !mul_req && sel_ok) acc_d[bus.acc_sel] = alu_res;
        if (bus.load_carry)      carry_d = alu_cy;
        else if (bus.init_carry) carry_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the accumulator file is a handful of flops that must read zero
      // after reset, so each entry is reset explicitly rather than left as RAM.
      for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
      r1_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      acc_q   <= acc_d;
      r1_q    <= r1_d;
      carry_q <= carry_d;
    end
  end

  assign bus.data_out = op_a;
  assign bus.zero     = (op_a == '0);
  assign bus.carry    = carry_q;

endmodule

// File: tb/tb_ut_param_core.sv
// Directed bench for ut_param_core (WIDTH=16, NACC=2); multiply checks are
// built when UT_PARAM_MUL_EN is defined, the tied-off behaviour otherwise.
module tb_ut_param_core;
  localparam int WIDTH = 16;
  localparam int NACC  = 2;
  localparam int AW    = 1;

  localparam logic [2:0] NOR  = 3'b000;
  localparam logic [2:0] PASS = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] SUB  = 3'b011;
  localparam logic [2:0] MUL  = 3'b100;
  localparam logic [2:0] RSV  = 3'b101;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   done_at;
  int   busy_cnt;
  int   done_seen;

  ut_param_core_if #(.WIDTH(WIDTH), .AW(AW)) bus_if ();

  ut_param_core #(.WIDTH(WIDTH), .NACC(NACC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_r1(input logic [WIDTH-1:0] v);
    bus_if.data_in = v;
    bus_if.load_r1 = 1'b1;
    tick();
    bus_if.load_r1 = 1'b0;
  endtask

  task automatic alu_op(input logic [2:0] sel, input logic lacc, input logic lcar, input logic icar);
    bus_if.sel_ual    = sel;
    bus_if.load_acc   = lacc;
    bus_if.load_carry = lcar;
    bus_if.init_carry = icar;
    tick();
    bus_if.load_acc   = 1'b0;
    bus_if.load_carry = 1'b0;
    bus_if.init_carry = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus_if.ce         = 1'b1;
    bus_if.sel_ual    = NOR;
    bus_if.acc_sel    = '0;
    bus_if.data_in    = '0;
    bus_if.load_r1    = 1'b0;
    bus_if.load_acc   = 1'b0;
    bus_if.load_carry = 1'b0;
    bus_if.init_carry = 1'b0;
    bus_if.start      = 1'b0;

    repeat (2) tick();
    check("rst_data_out", 32'(bus_if.data_out), 32'h0);
    check("rst_zero",     32'(bus_if.zero),     32'h1);
    check("rst_carry",    32'(bus_if.carry),    32'h0);
    check("rst_busy",     32'(bus_if.busy),     32'h0);
    check("rst_done",     32'(bus_if.done),     32'h0);
    rst = 1'b0;
    tick();

    // ADD wrapping to zero sets carry and zero
    load_r1(16'hFFFF);
    alu_op(PASS, 1'b1, 1'b0, 1'b0);
    check("pass_acc0", 32'(bus_if.data_out), 32'hFFFF);
    load_r1(16'h0001);
    alu_op(ADD, 1'b1, 1'b1, 1'b0);
    check("add_wrap_acc0",  32'(bus_if.data_out), 32'h0000);
    check("add_wrap_carry", 32'(bus_if.carry),    32'h1);
    check("add_wrap_zero",  32'(bus_if.zero),     32'h1);

    // NOR without load_carry leaves carry at 1
    load_r1(16'h0F00);
    alu_op(PASS, 1'b1, 1'b0, 1'b0);
    load_r1(16'h00F0);
    alu_op(NOR, 1'b1, 1'b0, 1'b0);
    check("nor_acc0",  32'(bus_if.data_out), 32'hF00F);
    check("nor_carry", 32'(bus_if.carry),    32'h1);

    // ce low freezes accumulators, R1 and carry
    bus_if.ce = 1'b0;
    load_r1(16'h1111);
    alu_op(PASS, 1'b1, 1'b0, 1'b1);
    check("ce_hold_acc0",  32'(bus_if.data_out), 32'hF00F);
    check("ce_hold_carry", 32'(bus_if.carry),    32'h1);
    bus_if.ce = 1'b1;
    alu_op(PASS, 1'b0, 1'b0, 1'b0);
    check("ce_hold_r1_unchanged", 32'(bus_if.data_out), 32'hF00F);

    // SUB on ACC1 with borrow
    alu_op(NOR, 1'b0, 1'b0, 1'b1);
    check("init_carry", 32'(bus_if.carry), 32'h0);
    bus_if.acc_sel = 1'b1;
    load_r1(16'h0003);
    alu_op(PASS, 1'b1, 1'b0, 1'b0);
    load_r1(16'h0005);
    alu_op(SUB, 1'b1, 1'b1, 1'b0);
    check("sub_acc1",  32'(bus_if.data_out), 32'hFFFE);
    check("sub_carry", 32'(bus_if.carry),    32'h1);
    bus_if.acc_sel = 1'b0;
    #1;
    check("sub_acc0_untouched", 32'(bus_if.data_out), 32'hF00F);

    // load_carry wins over init_carry on SUB with A<B
    bus_if.acc_sel = 1'b1;
    alu_op(NOR, 1'b0, 1'b0, 1'b1);
    load_r1(16'hFFFF);
    alu_op(SUB, 1'b0, 1'b1, 1'b1);
    check("carry_priority", 32'(bus_if.carry),    32'h1);
    check("carry_prio_acc", 32'(bus_if.data_out), 32'hFFFE);

    // ADD without overflow clears carry
    load_r1(16'h0001);
    alu_op(ADD, 1'b1, 1'b1, 1'b0);
    check("add_nc_acc1",  32'(bus_if.data_out), 32'hFFFF);
    check("add_nc_carry", 32'(bus_if.carry),    32'h0);
    check("add_nc_zero",  32'(bus_if.zero),     32'h0);

    // reserved code writes zero
    alu_op(RSV, 1'b1, 1'b0, 1'b0);
    check("rsv_acc1", 32'(bus_if.data_out), 32'h0000);
    check("rsv_zero", 32'(bus_if.zero),     32'h1);
    bus_if.acc_sel = 1'b0;

`ifdef UT_PARAM_MUL_EN
    // 0x1234 * 0x0100 with load_acc and R1 load mid-run
    load_r1(16'h1234);
    alu_op(PASS, 1'b1, 1'b0, 1'b0);
    load_r1(16'h0100);
    bus_if.sel_ual = MUL;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("mul_busy_start", 32'(bus_if.busy), 32'h1);
    busy_cnt = 1;
    done_at  = 0;
    for (int e = 1; e <= 40 && done_at == 0; e++) begin
      if (e == 5) begin
        bus_if.sel_ual  = PASS;
        bus_if.load_acc = 1'b1;
        bus_if.data_in  = 16'hFFFF;
        bus_if.load_r1  = 1'b1;
      end
      tick();
      bus_if.load_acc = 1'b0;
      bus_if.load_r1  = 1'b0;
      if (e == 5) check("mul_load_acc_ignored", 32'(bus_if.data_out), 32'h1234);
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) done_at = e;
    end
    check("mul_done_edge",  32'(done_at),          32'd17);
    check("mul_busy_count", 32'(busy_cnt),         32'd17);
    check("mul_result",     32'(bus_if.data_out),  32'h3400);
    check("mul_carry",      32'(bus_if.carry),     32'h1);
    tick();
    check("mul_done_pulse", 32'(bus_if.done), 32'h0);
    check("mul_idle_busy",  32'(bus_if.busy), 32'h0);

    // same multiply with ce low for edges 4..6
    load_r1(16'h1234);
    alu_op(PASS, 1'b1, 1'b0, 1'b0);
    load_r1(16'h0100);
    bus_if.sel_ual = MUL;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start = 1'b0;
    done_at = 0;
    for (int e = 1; e <= 40 && done_at == 0; e++) begin
      bus_if.ce = !(e >= 4 && e <= 6);
      tick();
      if (bus_if.done) done_at = e;
    end
    bus_if.ce = 1'b1;
    check("stall_done_edge", 32'(done_at),         32'd20);
    check("stall_result",    32'(bus_if.data_out), 32'h3400);

    // index is latched: acc_sel moves mid-run, result lands in ACC1
    bus_if.acc_sel = 1'b1;
    load_r1(16'h00FF);
    alu_op(PASS, 1'b1, 1'b0, 1'b0);
    load_r1(16'h0003);
    bus_if.sel_ual = MUL;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start = 1'b0;
    done_at = 0;
    for (int e = 1; e <= 40 && done_at == 0; e++) begin
      if (e == 3) bus_if.acc_sel = 1'b0;
      tick();
      if (bus_if.done) done_at = e;
    end
    check("idx_done_edge", 32'(done_at),         32'd17);
    check("idx_acc0_kept", 32'(bus_if.data_out), 32'h3400);
    check("idx_carry",     32'(bus_if.carry),    32'h0);
    bus_if.acc_sel = 1'b1;
    #1;
    check("idx_acc1_result", 32'(bus_if.data_out), 32'h02FD);
    bus_if.acc_sel = 1'b0;

    // reset mid-multiply aborts with no done pulse
    load_r1(16'h1234);
    alu_op(PASS, 1'b1, 1'b0, 1'b0);
    load_r1(16'h0100);
    bus_if.sel_ual = MUL;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #2;
    check("abort_busy",  32'(bus_if.busy),     32'h0);
    check("abort_done",  32'(bus_if.done),     32'h0);
    check("abort_data",  32'(bus_if.data_out), 32'h0);
    check("abort_carry", 32'(bus_if.carry),    32'h0);
    rst = 1'b0;
    done_seen = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (bus_if.done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen),       32'd0);
    check("abort_acc0",    32'(bus_if.data_out), 32'h0);
`else
    // multiplier absent: code 100 is reserved and start is ignored
    bus_if.sel_ual  = MUL;
    bus_if.start    = 1'b1;
    bus_if.load_acc = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    bus_if.load_acc = 1'b0;
    check("nomul_busy", 32'(bus_if.busy),     32'h0);
    check("nomul_data", 32'(bus_if.data_out), 32'h0);
    done_seen = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (bus_if.done || bus_if.busy) done_seen++;
    end
    check("nomul_no_done", 32'(done_seen), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
